// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample tick, mid-bit strobe and baud tick from one clock.
// The divisor is double-buffered and swaps at a baud boundary so a running bit is never distorted.
module baud_gen_frac #(
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int DIV_INT_RST  = 54,
    parameter int DIV_FRAC_RST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [DIV_W-1:0]  div_int_in,
    input  logic [FRAC_W-1:0] div_frac_in,
    output logic              tick_os,
    output logic              mid_tick,
    output logic              baud_tick,
    output logic              div_pending
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID_PRE = OS_W'(OVERSAMPLE / 2 - 1);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    logic [DIV_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pending;
    logic              r_en_d;
    logic [DIV_W:0]    r_cnt;
    logic [OS_W-1:0]   r_os;
    logic [FRAC_W-1:0] r_acc;
    logic              r_c;
    logic              r_tick_os;
    logic              r_mid;
    logic              r_baud;

    logic [DIV_W-1:0]  w_d_eff;
    logic [DIV_W:0]    w_last;
    logic              w_bnd;
    logic              w_baud_bnd;
    logic              w_mid_bnd;
    logic              w_rise;
    logic [FRAC_W:0]   w_sum;

    // Period length is D plus the carry left by the previous boundary.
    assign w_d_eff    = clamp_div(r_div_int);
    assign w_last     = {1'b0, w_d_eff} + {{DIV_W{1'b0}}, r_c} - (DIV_W+1)'(1);
    assign w_bnd      = en & ~sync & (r_cnt >= w_last);
    assign w_baud_bnd = w_bnd & (r_os == OS_LAST);
    assign w_mid_bnd  = w_bnd & (r_os == OS_MID_PRE);
    assign w_rise     = en & ~r_en_d;
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_div_frac};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_os      <= '0;
            r_acc     <= '0;
            r_c       <= 1'b0;
            r_tick_os <= 1'b0;
            r_mid     <= 1'b0;
            r_baud    <= 1'b0;
        end else begin
            r_tick_os <= w_bnd;
            r_mid     <= w_mid_bnd;
            r_baud    <= w_baud_bnd;
            if (!en || sync) begin
                r_cnt <= '0;
                r_os  <= '0;
                r_acc <= '0;
                r_c   <= 1'b0;
            end else if (w_bnd) begin
                r_cnt <= '0;
                r_os  <= (r_os == OS_LAST) ? '0 : r_os + 1'b1;
                r_acc <= w_sum[FRAC_W-1:0];
                r_c   <= w_sum[FRAC_W];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Disabled, sync or first enabled cycle: a write lands at once; otherwise it waits for a baud edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_int  <= DIV_W'(DIV_INT_RST);
            r_div_frac <= FRAC_W'(DIV_FRAC_RST);
            r_sh_int   <= '0;
            r_sh_frac  <= '0;
            r_pending  <= 1'b0;
            r_en_d     <= 1'b0;
        end else begin
            r_en_d <= en;
            if (div_wr) begin
                r_sh_int  <= div_int_in;
                r_sh_frac <= div_frac_in;
            end
            if (!en) begin
                if (div_wr) begin
                    r_div_int  <= div_int_in;
                    r_div_frac <= div_frac_in;
                    r_pending  <= 1'b0;
                end
            end else if (sync || w_rise) begin
                if (div_wr) begin
                    r_div_int  <= div_int_in;
                    r_div_frac <= div_frac_in;
                    r_pending  <= 1'b0;
                end else if (r_pending) begin
                    r_div_int  <= r_sh_int;
                    r_div_frac <= r_sh_frac;
                    r_pending  <= 1'b0;
                end
            end else begin
                if (w_baud_bnd && r_pending) begin
                    r_div_int  <= r_sh_int;
                    r_div_frac <= r_sh_frac;
                end
                if (div_wr) begin
                    r_pending <= 1'b1;
                end else if (w_baud_bnd) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    assign tick_os     = r_tick_os;
    assign mid_tick    = r_mid;
    assign baud_tick   = r_baud;
    assign div_pending = r_pending;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: a deadline-based reference model predicts every tick and pending state;
// a monitor on the falling edge pops predictions and compares them with the DUT.
module tb_baud_gen_frac;

    localparam int OS   = 4;
    localparam int DW   = 16;
    localparam int FW   = 4;
    localparam int DRST = 5;
    localparam int FRST = 0;

    logic          clk;
    logic          reset;
    logic          en;
    logic          sync;
    logic          div_wr;
    logic [DW-1:0] div_int_in;
    logic [FW-1:0] div_frac_in;
    logic          tick_os;
    logic          mid_tick;
    logic          baud_tick;
    logic          div_pending;

    typedef struct {
        int t;
        int mid;
        int baud;
    } ev_t;

    ev_t exp_q[$];
    int  seen_t[$];
    int  exp_pend = 0;
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    baud_gen_frac #(
        .OVERSAMPLE  (OS),
        .DIV_W       (DW),
        .FRAC_W      (FW),
        .DIV_INT_RST (DRST),
        .DIV_FRAC_RST(FRST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sync       (sync),
        .div_wr     (div_wr),
        .div_int_in (div_int_in),
        .div_frac_in(div_frac_in),
        .tick_os    (tick_os),
        .mid_tick   (mid_tick),
        .baud_tick  (baud_tick),
        .div_pending(div_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference model: each period ends at an absolute edge number; ticks are numbered since restart.
    initial begin : model
        int  act_d, act_f, sh_d, sh_f, pend, en_prev, n, acc, carry, nb, sum;
        ev_t ev;
        act_d = DRST; act_f = FRST; sh_d = 0; sh_f = 0; pend = 0; en_prev = 0;
        n = 0; acc = 0; carry = 0; nb = 0; sum = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                act_d = DRST; act_f = FRST; sh_d = 0; sh_f = 0; pend = 0; en_prev = 0;
                n = 0; acc = 0; carry = 0;
                nb = cyc + eff(act_d);
                exp_q.delete();
                exp_pend = 0;
            end else begin
                cyc++;
                if (!en) begin
                    if (div_wr) begin
                        act_d = int'(div_int_in); act_f = int'(div_frac_in);
                        sh_d = act_d; sh_f = act_f; pend = 0;
                    end
                    n = 0; acc = 0; carry = 0;
                    nb = cyc + eff(act_d);
                end else if (sync) begin
                    if (div_wr) begin
                        act_d = int'(div_int_in); act_f = int'(div_frac_in);
                        sh_d = act_d; sh_f = act_f; pend = 0;
                    end else if (pend != 0) begin
                        act_d = sh_d; act_f = sh_f; pend = 0;
                    end
                    n = 0; acc = 0; carry = 0;
                    nb = cyc + eff(act_d);
                end else if (en_prev == 0 && (div_wr || pend != 0)) begin
                    if (div_wr) begin
                        sh_d = int'(div_int_in); sh_f = int'(div_frac_in);
                    end
                    act_d = sh_d; act_f = sh_f; pend = 0;
                    nb = cyc - 1 + eff(act_d);
                end else if (cyc == nb) begin
                    n++;
                    ev.t    = cyc;
                    ev.mid  = (n % OS == OS / 2) ? 1 : 0;
                    ev.baud = (n % OS == 0) ? 1 : 0;
                    exp_q.push_back(ev);
                    sum   = acc + act_f;
                    carry = sum / (1 << FW);
                    acc   = sum % (1 << FW);
                    if (ev.baud == 1 && pend != 0) begin
                        act_d = sh_d; act_f = sh_f; pend = 0;
                    end
                    if (div_wr) begin
                        sh_d = int'(div_int_in); sh_f = int'(div_frac_in); pend = 1;
                    end
                    nb = cyc + eff(act_d) + carry;
                end else if (div_wr) begin
                    sh_d = int'(div_int_in); sh_f = int'(div_frac_in); pend = 1;
                end
                en_prev  = en ? 1 : 0;
                exp_pend = pend;
            end
        end
    end

    initial begin : monitor
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tick_os) begin
                    seen_t.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tick", int'(tick_os), 0);
                    end else begin
                        ev = exp_q.pop_front();
                        chk("tick_cycle", cyc, ev.t);
                        chk("mid_tick", int'(mid_tick), ev.mid);
                        chk("baud_tick", int'(baud_tick), ev.baud);
                    end
                end else begin
                    if (mid_tick || baud_tick)
                        chk("sub_tick_without_tick_os", int'(mid_tick) + int'(baud_tick), 0);
                    if (exp_q.size() != 0 && exp_q[0].t <= cyc) begin
                        ev = exp_q.pop_front();
                        chk("missing_tick", int'(tick_os), 1);
                    end
                end
                chk("div_pending", int'(div_pending), exp_pend);
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr(input int d, input int f);
        div_wr      = 1'b1;
        div_int_in  = DW'(d);
        div_frac_in = FW'(f);
        @(negedge clk);
        div_wr = 1'b0;
    endtask

    task automatic wait_tick();
        int ok;
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (tick_os) ok = 1;
        end
        if (ok == 0) chk("tick_timeout", int'(tick_os), 1);
    endtask

    task automatic wait_baud();
        int ok;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            wait_tick();
            if (baud_tick) ok = 1;
        end
        if (ok == 0) chk("baud_timeout", int'(baud_tick), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_tick_os"}, int'(tick_os), 0);
        chk({nm, "_mid_tick"}, int'(mid_tick), 0);
        chk({nm, "_baud_tick"}, int'(baud_tick), 0);
        chk({nm, "_div_pending"}, int'(div_pending), 0);
    endtask

    initial begin : stim
        int r;
        int span;
        reset = 1'b1; en = 1'b1; sync = 1'b0; div_wr = 1'b0;
        div_int_in = '0; div_frac_in = '0;
        cycles(3);
        chk_all_zero("reset");
        reset = 1'b0;

        // Reset divisor D=5, F=0: tick every 5, baud every 20
        cycles(60);

        // D=5, F=8 loaded while disabled; 16 steady-state periods span 88 cycles
        en = 1'b0;
        wr(5, 8);
        seen_t.delete();
        en = 1'b1;
        cycles(120);
        span = (seen_t.size() >= 18) ? seen_t[17] - seen_t[1] : -1;
        chk("span_16_periods", span, 88);

        // Deferred divisor update, then overwrite before the boundary
        wait_tick();
        cycles(1);
        wr(8, 0);
        chk("pending_after_wr", int'(div_pending), 1);
        cycles(70);
        wait_baud();
        wr(10, 0);
        cycles(2);
        wr(3, 0);
        cycles(60);

        // sync two cycles after a tick, then sync coincident with a boundary
        wait_tick();
        cycles(1);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        cycles(30);
        wait_tick();
        cycles(2);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        cycles(30);

        // Pending write survives en low and applies on en rise; write while low is immediate
        wait_baud();
        wr(4, 0);
        en = 1'b0;
        cycles(30);
        en = 1'b1;
        cycles(50);
        en = 1'b0;
        cycles(5);
        wr(7, 0);
        cycles(24);
        en = 1'b1;
        cycles(60);

        // Asynchronous reset while baud_tick is high
        wait_baud();
        #1 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        cycles(2);
        reset = 1'b0;
        cycles(30);

        // Divisors 0 and 1 clamp to 2
        en = 1'b0;
        wr(0, 0);
        en = 1'b1;
        cycles(30);
        en = 1'b0;
        wr(1, 0);
        en = 1'b1;
        cycles(30);

        // Randomized control traffic
        for (int i = 0; i < 2000; i++) begin
            r           = $urandom_range(0, 999);
            sync        = (r < 10);
            div_wr      = (r >= 10 && r < 30);
            div_int_in  = DW'($urandom_range(0, 9));
            div_frac_in = FW'($urandom_range(0, 15));
            if (en) begin
                if (r >= 990) en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                en = 1'b1;
            end
            @(negedge clk);
        end
        sync = 1'b0;
        div_wr = 1'b0;
        en = 1'b1;
        cycles(40);
        en = 1'b0;
        cycles(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
